// File: rtl/config_read_register_bank.sv
// Read-only bank of configuration registers behind one read request/response port.
// Decodes a byte address to a register index, holds the response until consumed, and
// keeps per-register sticky event accumulators that clear when read.
module config_read_register_bank #(
    parameter int unsigned                AXIL_ADDR_BITS = 32,
    parameter int unsigned                AXIL_DATA_BITS = 32,
    parameter int unsigned                NUM_REGS       = 4,
    parameter logic [AXIL_ADDR_BITS-1:0]  BASE_ADDR      = '0,
    parameter int unsigned                ADDR_STRIDE    = 8,
    parameter int unsigned                VALUE_BITS     = 32,
    parameter logic [NUM_REGS-1:0]        STICKY_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           read_valid_i,
    output logic                           read_ready_o,
    input  logic [AXIL_ADDR_BITS-1:0]      read_addr_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [AXIL_DATA_BITS-1:0]      resp_data_o,
    output logic                           resp_error_o,
    input  logic [NUM_REGS*VALUE_BITS-1:0] values_i
);

    localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STRIDE_LOG = $clog2(ADDR_STRIDE);
    localparam logic [AXIL_ADDR_BITS-1:0] ALIGN_MASK = AXIL_ADDR_BITS'(ADDR_STRIDE - 1);
    localparam logic [AXIL_ADDR_BITS:0]   SPAN       = (AXIL_ADDR_BITS + 1)'(NUM_REGS * ADDR_STRIDE);

    if (VALUE_BITS > AXIL_DATA_BITS) begin : g_chk_value_bits
        $error("VALUE_BITS must not exceed AXIL_DATA_BITS");
    end
    if (NUM_REGS < 1) begin : g_chk_num_regs
        $error("NUM_REGS must be at least 1");
    end
    if ((ADDR_STRIDE == 0) || ((ADDR_STRIDE & (ADDR_STRIDE - 1)) != 0)) begin : g_chk_stride
        $error("ADDR_STRIDE must be a power of two");
    end
    if ((BASE_ADDR & ALIGN_MASK) != '0) begin : g_chk_base
        $error("BASE_ADDR must be a multiple of ADDR_STRIDE");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        RESPOND = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [AXIL_DATA_BITS-1:0] resp_data_q, resp_data_d;
    logic                      resp_error_q, resp_error_d;
    logic [VALUE_BITS-1:0]     acc_q [NUM_REGS];
    logic [VALUE_BITS-1:0]     acc_d [NUM_REGS];

    logic                      accept;
    logic [AXIL_ADDR_BITS:0]   offset_w;
    logic                      addr_hit;
    logic [IDX_W-1:0]          addr_idx;
    logic [VALUE_BITS-1:0]     snap_value;
    logic [NUM_REGS-1:0]       acc_clr;

    assign read_ready_o = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESPOND);
    assign resp_data_o  = resp_data_q;
    assign resp_error_o = resp_error_q;
    assign accept       = read_valid_i && (state_q == IDLE);

    // The extra top bit makes an address below BASE_ADDR wrap far above SPAN,
    // so one unsigned compare covers both ends of the range.
    assign offset_w = {1'b0, read_addr_i} - {1'b0, BASE_ADDR};
    assign addr_hit = (offset_w < SPAN) && ((offset_w[AXIL_ADDR_BITS-1:0] & ALIGN_MASK) == '0);
    assign addr_idx = IDX_W'(offset_w[AXIL_ADDR_BITS-1:0] >> STRIDE_LOG);

    // NOTE: every variable driven here gets a default before the loop; without it a
    // path that skips the assignment would hold the old value and infer a latch.
    always_comb begin
        snap_value = '0;
        acc_clr    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_idx == IDX_W'(i)) begin
                snap_value = STICKY_MASK[i]
                           ? (acc_q[i] | values_i[i*VALUE_BITS +: VALUE_BITS])
                           : values_i[i*VALUE_BITS +: VALUE_BITS];
                acc_clr[i] = accept && addr_hit && STICKY_MASK[i];
            end
        end
    end

    // The live input is folded into the snapshot, so clearing here loses no event.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!STICKY_MASK[i] || acc_clr[i]) begin
                acc_d[i] = '0;
            end else begin
                acc_d[i] = acc_q[i] | values_i[i*VALUE_BITS +: VALUE_BITS];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        unique case (state_q)
            IDLE: begin
                if (read_valid_i) begin
                    state_d      = RESPOND;
                    resp_error_d = !addr_hit;
                    resp_data_d  = addr_hit ? AXIL_DATA_BITS'(snap_value) : '0;
                end
            end
            RESPOND: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    // NOTE: the accumulator array is reset on purpose: a reset must discard events
    // collected before it, so this storage cannot be left uninitialised like a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_config_read_register_bank.sv
// Self-checking bench for config_read_register_bank: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a behavioural model.
module tb_config_read_register_bank;

    localparam int unsigned     NUM    = 4;
    localparam int unsigned     VB     = 16;
    localparam int unsigned     STRIDE = 8;
    localparam logic [31:0]     BASE   = 32'h100;
    localparam logic [NUM-1:0]  STICKY = 4'b1001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          read_valid_i = 1'b0;
    logic          read_ready_o;
    logic [31:0]   read_addr_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [31:0]   resp_data_o;
    logic          resp_error_o;
    logic [VB-1:0] val [NUM] = '{16'h11, 16'h22, 16'h33, 16'h44};
    logic [NUM*VB-1:0] values_i;

    int n_cmp  = 0;
    int n_fail = 0;

    assign values_i = {val[3], val[2], val[1], val[0]};

    always #5 clk = ~clk;

    config_read_register_bank #(
        .AXIL_ADDR_BITS(32),
        .AXIL_DATA_BITS(32),
        .NUM_REGS      (NUM),
        .BASE_ADDR     (BASE),
        .ADDR_STRIDE   (STRIDE),
        .VALUE_BITS    (VB),
        .STICKY_MASK   (STICKY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_valid_i(read_valid_i),
        .read_ready_o(read_ready_o),
        .read_addr_i (read_addr_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .resp_data_o (resp_data_o),
        .resp_error_o(resp_error_o),
        .values_i    (values_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one outstanding read, a pending snapshot, and an OR-accumulator
    // per sticky register, all derived from the address arithmetic of the bank.
    logic          m_busy = 1'b0;
    logic [31:0]   m_data = '0;
    logic          m_err  = 1'b0;
    logic [VB-1:0] m_acc [NUM] = '{default: '0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_data = '0;
            m_err  = 1'b0;
            for (int i = 0; i < NUM; i++) m_acc[i] = '0;
        end else begin
            int clr;
            longint unsigned a;
            logic [VB-1:0] v [NUM];
            clr = -1;
            for (int i = 0; i < NUM; i++) v[i] = values_i[i*VB +: VB];
            if (m_busy) begin
                if (resp_ready_i) m_busy = 1'b0;
            end else if (read_valid_i) begin
                a = read_addr_i;
                if (a >= BASE && a < BASE + NUM * STRIDE && (a % STRIDE) == 0) begin
                    int k;
                    k = int'((a - BASE) / STRIDE);
                    m_data = STICKY[k] ? {16'h0, m_acc[k] | v[k]} : {16'h0, v[k]};
                    m_err  = 1'b0;
                    if (STICKY[k]) clr = k;
                end else begin
                    m_data = '0;
                    m_err  = 1'b1;
                end
                m_busy = 1'b1;
            end
            for (int i = 0; i < NUM; i++) begin
                if (STICKY[i]) m_acc[i] = (i == clr) ? '0 : (m_acc[i] | v[i]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("read_ready", {31'h0, read_ready_o}, {31'h0, !m_busy});
            check("resp_valid", {31'h0, resp_valid_o}, {31'h0, m_busy});
            if (m_busy) begin
                check("resp_data",  resp_data_o, m_data);
                check("resp_error", {31'h0, resp_error_o}, {31'h0, m_err});
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic start_read(input logic [31:0] addr);
        int n;
        n = 0;
        while (!read_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'h0, read_ready_o}, 32'h1);
        read_valid_i = 1'b1;
        read_addr_i  = addr;
        @(negedge clk);
        read_valid_i = 1'b0;
        check("resp_latency", {31'h0, resp_valid_o}, 32'h1);
    endtask

    task automatic finish_read(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ready_low", {31'h0, read_ready_o}, 32'h0);
            check("hold_valid", {31'h0, resp_valid_o}, 32'h1);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        check("back_to_idle", {31'h0, read_ready_o}, 32'h1);
        check("valid_dropped", {31'h0, resp_valid_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_read_ready", {31'h0, read_ready_o}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
        check("rst_resp_data",  resp_data_o, 32'h0);
        check("rst_resp_error", {31'h0, resp_error_o}, 32'h0);

        // Plain read of register 2 with backpressure and a live value change.
        start_read(32'h110);
        check("rd110_data", resp_data_o, 32'h33);
        check("rd110_err",  {31'h0, resp_error_o}, 32'h0);
        val[2] = 16'hAA;
        finish_read(5);
        check("rd110_data_held", resp_data_o, 32'h33);

        // Decode misses and the edges of the range.
        start_read(32'h120);
        check("past_end_err",  {31'h0, resp_error_o}, 32'h1);
        check("past_end_data", resp_data_o, 32'h0);
        finish_read(0);
        start_read(32'h104);
        check("misaligned_err", {31'h0, resp_error_o}, 32'h1);
        finish_read(0);
        start_read(32'h0F8);
        check("below_base_err", {31'h0, resp_error_o}, 32'h1);
        finish_read(0);
        start_read(32'h118);
        check("last_reg_data", resp_data_o, 32'h44);
        check("last_reg_err",  {31'h0, resp_error_o}, 32'h0);
        finish_read(0);

        // Sticky register 0: drain, then accumulate pulses.
        val[0] = 16'h0;
        start_read(32'h100);
        check("sticky_drain", resp_data_o, 32'h11);
        finish_read(0);
        @(negedge clk); val[0] = 16'h1;
        @(negedge clk); val[0] = 16'h0;
        @(negedge clk); val[0] = 16'h4;
        @(negedge clk); val[0] = 16'h0;
        @(negedge clk); val[0] = 16'h8;
        start_read(32'h100);
        check("sticky_snap", resp_data_o, 32'hD);
        val[0] = 16'h2;
        @(negedge clk); val[0] = 16'h0;
        finish_read(1);
        start_read(32'h100);
        check("sticky_during_resp", resp_data_o, 32'h2);
        finish_read(0);

        // Asynchronous reset while a response is pending.
        val[0] = 16'h10;
        @(negedge clk); val[0] = 16'h0;
        start_read(32'h110);
        #2 rst = 1'b1;
        #1;
        check("async_drop_valid", {31'h0, resp_valid_o}, 32'h0);
        check("async_ready",      {31'h0, read_ready_o}, 32'h1);
        check("async_data_zero",  resp_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        val[0] = 16'h20;
        @(negedge clk); val[0] = 16'h0;
        start_read(32'h100);
        check("post_reset_sticky", resp_data_o, 32'h20);
        finish_read(0);

        // Randomized traffic checked by the per-cycle compare process.
        repeat (500) begin
            @(negedge clk);
            read_valid_i = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: read_addr_i = BASE + STRIDE * $urandom_range(0, NUM - 1);
                1: read_addr_i = BASE - 32'h10 + $urandom_range(0, 32'h40);
                2: read_addr_i = $urandom;
                default: read_addr_i = ($urandom_range(0, 1) != 0) ? 32'h0F8 : 32'h120;
            endcase
            resp_ready_i = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NUM; i++) begin
                if (STICKY[i])
                    val[i] = ($urandom_range(0, 3) == 0) ? VB'(1 << $urandom_range(0, VB - 1)) : '0;
                else
                    val[i] = VB'($urandom);
            end
        end
        @(negedge clk);
        read_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
